// File: rtl/tdm_if.sv
// Slot-multiplexed bus bundle between a TDM source and tdm_demux.
// The source drives the beat signals and the demux returns the published frame and status.
interface tdm_if #(
  parameter int WIDTH  = 2,
  parameter int SLOTS  = 4,
  parameter int SLOT_W = 2
);
  logic                   in_valid;
  logic                   in_sync;
  logic [WIDTH-1:0]       in_data;
  logic [SLOTS*WIDTH-1:0] ch_data;
  logic                   frame_valid;
  logic                   locked;
  logic [SLOT_W-1:0]      slot;
  logic                   frame_err;

  modport master (
    output in_valid, in_sync, in_data,
    input  ch_data, frame_valid, locked, slot, frame_err
  );

  modport slave (
    input  in_valid, in_sync, in_data,
    output ch_data, frame_valid, locked, slot, frame_err
  );
endinterface

// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: locks onto the slot-0 sync bit, routes each word to a
// shadow register, and publishes the whole frame at once; framing faults pulse frame_err.
module tdm_demux #(
  parameter int WIDTH  = 2,
  parameter int SLOTS  = 4,
  parameter int SLOT_W = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  tdm_if.slave  bus
);
  typedef enum logic {HUNT, RUN} state_t;

  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(SLOTS - 1);

  state_t                 r_state, w_state_nxt;
  logic [SLOT_W-1:0]      r_slot, w_slot_nxt;
  logic                   w_load0, w_store, w_publish, w_err;
  logic [WIDTH-1:0]       r_shadow [SLOTS-1];
  logic [SLOTS*WIDTH-1:0] r_ch_data;
  logic                   r_frame_valid;
  logic                   r_frame_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT;
      r_slot  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
    end
  end

  // A sync beat is always accepted as slot 0, even mid-frame, so a slipped source relocks at once.
  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_load0     = 1'b0;
    w_store     = 1'b0;
    w_publish   = 1'b0;
    w_err       = 1'b0;
    if (bus.in_valid) begin
      case (r_state)
        HUNT: begin
          if (bus.in_sync) begin
            w_load0     = 1'b1;
            w_slot_nxt  = SLOT_W'(1);
            w_state_nxt = RUN;
          end
        end
        RUN: begin
          if (bus.in_sync) begin
            w_load0    = 1'b1;
            w_slot_nxt = SLOT_W'(1);
            w_err      = (r_slot != '0);
          end else if (r_slot == '0) begin
            w_err       = 1'b1;
            w_state_nxt = HUNT;
          end else if (r_slot == LAST) begin
            w_publish  = 1'b1;
            w_slot_nxt = '0;
          end else begin
            w_store    = 1'b1;
            w_slot_nxt = r_slot + SLOT_W'(1);
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  // The last word bypasses the shadow bank and lands in ch_data on the publish edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SLOTS - 1; k++) r_shadow[k] <= '0;
      r_ch_data     <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_frame_valid <= w_publish;
      r_frame_err   <= w_err;
      if (w_load0) r_shadow[0] <= bus.in_data;
      if (w_store) r_shadow[r_slot] <= bus.in_data;
      if (w_publish) begin
        for (int k = 0; k < SLOTS - 1; k++) r_ch_data[k*WIDTH +: WIDTH] <= r_shadow[k];
        r_ch_data[(SLOTS-1)*WIDTH +: WIDTH] <= bus.in_data;
      end
    end
  end

  assign bus.ch_data     = r_ch_data;
  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_err   = r_frame_err;
  assign bus.locked      = (r_state == RUN);
  assign bus.slot        = r_slot;
endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (WIDTH=2, SLOTS=4) with a queue of expected published frames.
module tb_tdm_demux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] exp_q[$];

  tdm_if #(.WIDTH(2), .SLOTS(4), .SLOT_W(2)) bus ();

  tdm_demux #(.WIDTH(2), .SLOTS(4), .SLOT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, clock it, then compare pulses and any frame due from the scoreboard.
  task automatic cyc(input logic v, input logic s, input logic [1:0] d, input logic err_exp);
    logic [7:0] e;
    bus.in_valid = v;
    bus.in_sync  = s;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("frame_valid_pulse", 32'(bus.frame_valid), 32'd1);
      chk("ch_data_publish", 32'(bus.ch_data), 32'(e));
    end else begin
      chk("frame_valid_idle", 32'(bus.frame_valid), 32'd0);
    end
    chk("frame_err", 32'(bus.frame_err), 32'(err_exp));
  endtask

  task automatic beat(input logic s, input logic [1:0] d);
    cyc(1'b1, s, d, 1'b0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
    bus.in_data  = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: idle after reset
    repeat (2) cyc(1'b0, 1'b1, 2'b11, 1'b0);
    chk("reset_ch_data", 32'(bus.ch_data), 32'h00);
    chk("reset_locked", 32'(bus.locked), 32'd0);
    chk("reset_slot", 32'(bus.slot), 32'd0);

    // 2: back-to-back frame
    beat(1'b1, 2'b01);
    chk("t2_locked_beat1", 32'(bus.locked), 32'd1);
    chk("t2_slot_beat1", 32'(bus.slot), 32'd1);
    beat(1'b0, 2'b10);
    beat(1'b0, 2'b11);
    exp_q.push_back(8'h39);
    beat(1'b0, 2'b00);
    cyc(1'b0, 1'b0, 2'b00, 1'b0);
    chk("t2_hold_ch_data", 32'(bus.ch_data), 32'h39);

    // 3: same frame with a 3-cycle gap; payload changed then restored to prove republish
    beat(1'b1, 2'b11);
    beat(1'b0, 2'b11);
    beat(1'b0, 2'b11);
    exp_q.push_back(8'hFF);
    beat(1'b0, 2'b11);
    beat(1'b1, 2'b01);
    beat(1'b0, 2'b10);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 2'b01, 1'b0);
      chk("t3_gap_slot", 32'(bus.slot), 32'd2);
    end
    beat(1'b0, 2'b11);
    exp_q.push_back(8'h39);
    beat(1'b0, 2'b00);

    // 4: early sync on beat 3 relocks and discards the partial frame
    beat(1'b1, 2'b11);
    beat(1'b0, 2'b01);
    cyc(1'b1, 1'b1, 2'b10, 1'b1);
    chk("t4_relock_slot", 32'(bus.slot), 32'd1);
    chk("t4_relock_locked", 32'(bus.locked), 32'd1);
    beat(1'b0, 2'b00);
    chk("t4_no_publish", 32'(bus.ch_data), 32'h39);
    beat(1'b0, 2'b01);
    exp_q.push_back(8'hD2);
    beat(1'b0, 2'b11);

    // 5: missing sync at slot 0 drops to HUNT
    cyc(1'b1, 1'b0, 2'b11, 1'b1);
    chk("t5_unlocked", 32'(bus.locked), 32'd0);
    chk("t5_slot", 32'(bus.slot), 32'd0);
    beat(1'b0, 2'b01);
    beat(1'b0, 2'b10);
    chk("t5_still_hunt", 32'(bus.locked), 32'd0);
    chk("t5_ch_data_held", 32'(bus.ch_data), 32'hD2);
    beat(1'b1, 2'b00);
    beat(1'b0, 2'b01);
    beat(1'b0, 2'b10);
    exp_q.push_back(8'hE4);
    beat(1'b0, 2'b11);

    // 6: reset mid-frame
    beat(1'b1, 2'b01);
    beat(1'b0, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ch_data", 32'(bus.ch_data), 32'h00);
    chk("t6_rst_locked", 32'(bus.locked), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    beat(1'b0, 2'b10);
    chk("t6_needs_sync", 32'(bus.locked), 32'd0);
    beat(1'b1, 2'b10);
    beat(1'b0, 2'b10);
    beat(1'b0, 2'b10);
    exp_q.push_back(8'hAA);
    beat(1'b0, 2'b10);
    cyc(1'b0, 1'b0, 2'b00, 1'b0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
